alu_arbiter: RTL and testbench

Shares the single `alu` instance between two requesters (e.g. two execution lanes) with round-robin arbitration and a valid/ready request handshake. It issues at most one operation per cycle into the ALU. It tracks in-flight operations in a tag pipeline matched to the ALU latency and returns each result to its originator as a one-cycle response pulse. It sits between the issue logic and the `alu` datapath.

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
// Round-robin grant, valid/ready acceptance, registered ALU operands, and a
// tag pipeline matched to ALU_LATENCY that routes each result back to its
// originator as a one-cycle response pulse (responses return in order).
// Optional feature macro: ALU_ARB_STATS_EN adds saturating per-requester
// acceptance counters; without it grant_cnt0/grant_cnt1 read as 0.
module alu_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int ALU_LATENCY = 1    // legal range 1..4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2:0]           req0_op,
    input  logic [WORD_SIZE-1:0] req0_in1,
    input  logic [WORD_SIZE-1:0] req0_in2,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2:0]           req1_op,
    input  logic [WORD_SIZE-1:0] req1_in1,
    input  logic [WORD_SIZE-1:0] req1_in2,
    output logic                 rsp0_valid,
    output logic [WORD_SIZE-1:0] rsp0_data,
    output logic                 rsp1_valid,
    output logic [WORD_SIZE-1:0] rsp1_data,
    output logic [2:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic [15:0]          grant_cnt0,
    output logic [15:0]          grant_cnt1
);

    // last_grant: id of the requester accepted most recently (1 after reset,
    // so requester 0 wins the first contention).
    logic last_grant;
    logic gnt0, gnt1;
    logic acc0, acc1, acc;

    // Tag pipeline: stage k holds the operation issued k+1 edges ago.
    // Index ALU_LATENCY is the stage whose result is on alu_out.
    logic [ALU_LATENCY:0] tag_vld;
    logic [ALU_LATENCY:0] tag_id;
    logic                 tag_out_vld;
    logic                 tag_out_id;

    // Round-robin grant: contention goes to the requester not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    // Ready is masked by reset so nothing is accepted on a reset edge.
    assign req0_ready = gnt0 & rst_n;
    assign req1_ready = gnt1 & rst_n;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign acc        = acc0 | acc1;

    // Issue register: load the winner's operation, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_op     <= 3'd0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            last_grant <= 1'b1;
        end else if (acc0) begin
            alu_op     <= req0_op;
            alu_in1    <= req0_in1;
            alu_in2    <= req0_in2;
            last_grant <= 1'b0;
        end else if (acc1) begin
            alu_op     <= req1_op;
            alu_in1    <= req1_in1;
            alu_in2    <= req1_in2;
            last_grant <= 1'b1;
        end
    end

    // Tag shift register; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[ALU_LATENCY-1:0], acc};
            tag_id  <= {tag_id[ALU_LATENCY-1:0], acc1};
        end
    end

    assign tag_out_vld = tag_vld[ALU_LATENCY];
    assign tag_out_id  = tag_id[ALU_LATENCY];

    // Response capture: route alu_out to the tagged requester; data holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= tag_out_vld & ~tag_out_id;
            rsp1_valid <= tag_out_vld & tag_out_id;
            if (tag_out_vld && !tag_out_id) rsp0_data <= alu_out;
            if (tag_out_vld && tag_out_id)  rsp1_data <= alu_out;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating acceptance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (acc0 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (acc1 && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = 16'd0;
    assign grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter. Two instances: ALU_LATENCY=1
// (main) and ALU_LATENCY=3 (latency check), each fed by a behavioural ALU.
module tb_alu_arbiter;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, SLT = 3'd3,
                           AND = 3'd4, OR_ = 3'd5, XOR = 3'd6, SHF = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- main DUT (ALU_LATENCY = 1) ----------------
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic [15:0] req0_in1 = 0, req0_in2 = 0, req1_in1 = 0, req1_in2 = 0;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data;
    logic [2:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [15:0] grant_cnt0, grant_cnt1;

    alu_arbiter #(.WORD_SIZE(16), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // ---------------- second DUT (ALU_LATENCY = 3) ----------------
    logic        b_req0_valid = 0, b_req1_valid = 0;
    logic        b_req0_ready, b_req1_ready;
    logic [2:0]  b_req0_op = 0, b_req1_op = 0;
    logic [15:0] b_req0_in1 = 0, b_req0_in2 = 0, b_req1_in1 = 0, b_req1_in2 = 0;
    logic        b_rsp0_valid, b_rsp1_valid;
    logic [15:0] b_rsp0_data, b_rsp1_data;
    logic [2:0]  b_alu_op;
    logic [15:0] b_alu_in1, b_alu_in2, b_alu_out;
    logic [15:0] b_grant_cnt0, b_grant_cnt1;

    alu_arbiter #(.WORD_SIZE(16), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
        .req0_in1(b_req0_in1), .req0_in2(b_req0_in2),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
        .req1_in1(b_req1_in1), .req1_in2(b_req1_in2),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
        .alu_op(b_alu_op), .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_out(b_alu_out),
        .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1)
    );

    // Behavioural ALU function.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            MUL:     return a * b;
            SLT:     return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            AND:     return a & b;
            OR_:     return a | b;
            XOR:     return a ^ b;
            default: return a << b[3:0];
        endcase
    endfunction

    // Registered ALU models: 1 stage and 3 stages.
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        alu_out <= alu_f(alu_op, alu_in1, alu_in2);
        p3[0]   <= alu_f(b_alu_op, b_alu_in1, b_alu_in2);
        p3[1]   <= p3[0];
        p3[2]   <= p3[1];
    end
    assign b_alu_out = p3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v0, input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic v1, input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1);
        req0_valid = v0; req0_op = o0; req0_in1 = a0; req0_in2 = b0;
        req1_valid = v1; req1_op = o1; req1_in1 = a1; req1_in2 = b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v0; logic [2:0] op0; logic [15:0] a0; logic [15:0] b0;
        logic v1; logic [2:0] op1; logic [15:0] a1; logic [15:0] b1;
        logic rdy0; logic rdy1;
        logic rv0; logic [15:0] rd0;
        logic rv1; logic [15:0] rd1;
    } vec_t;

    vec_t tbl [23];
    logic [15:0] exp_c0, exp_c1;

    initial begin
        // Row r: inputs before edge r, readies before edge r, responses after edge r.
        tbl[0]  = '{0,0,0,0,   1,ADD,5,7,     0,1, 0,0,  0,0};
        tbl[1]  = '{0,0,0,0,   1,SUB,15,4,    0,1, 0,0,  0,0};
        tbl[2]  = '{0,0,0,0,   1,MUL,4,9,     0,1, 0,0,  1,12};
        tbl[3]  = '{0,0,0,0,   1,SLT,5,7,     0,1, 0,0,  1,11};
        tbl[4]  = '{0,0,0,0,   1,AND,9,12,    0,1, 0,0,  1,36};
        tbl[5]  = '{0,0,0,0,   1,OR_,9,12,    0,1, 0,0,  1,1};
        tbl[6]  = '{0,0,0,0,   1,XOR,9,12,    0,1, 0,0,  1,8};
        tbl[7]  = '{0,0,0,0,   1,SHF,5,3,     0,1, 0,0,  1,13};
        tbl[8]  = '{0,0,0,0,   0,0,0,0,       0,0, 0,0,  1,5};
        tbl[9]  = '{0,0,0,0,   0,0,0,0,       0,0, 0,0,  1,40};
        tbl[10] = '{0,0,0,0,   0,0,0,0,       0,0, 0,0,  0,40};
        tbl[11] = '{1,SUB,15,4, 1,MUL,4,9,    1,0, 0,0,  0,40};
        tbl[12] = '{0,0,0,0,   1,MUL,4,9,     0,1, 0,0,  0,40};
        tbl[13] = '{0,0,0,0,   0,0,0,0,       0,0, 1,11, 0,40};
        tbl[14] = '{0,0,0,0,   0,0,0,0,       0,0, 0,11, 1,36};
        tbl[15] = '{0,0,0,0,   0,0,0,0,       0,0, 0,11, 0,36};
        tbl[16] = '{1,ADD,1,2,  1,ADD,3,4,    1,0, 0,11, 0,36};
        tbl[17] = '{1,ADD,10,20, 1,ADD,3,4,   0,1, 0,11, 0,36};
        tbl[18] = '{1,ADD,10,20, 1,ADD,30,40, 1,0, 1,3,  0,36};
        tbl[19] = '{0,0,0,0,   1,ADD,30,40,   0,1, 0,3,  1,7};
        tbl[20] = '{0,0,0,0,   0,0,0,0,       0,0, 1,30, 0,7};
        tbl[21] = '{0,0,0,0,   0,0,0,0,       0,0, 0,30, 1,70};
        tbl[22] = '{0,0,0,0,   0,0,0,0,       0,0, 0,30, 0,70};

        // ---- reset state, with both requesters asserting valid ----
        rst_n = 1'b0;
        drv(1, SUB, 15, 4, 1, MUL, 4, 9);
        step();
        step();
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_rsp1_data", rsp1_data, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_alu_in2", alu_in2, 0);
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);

        // ---- contention out of reset: req0 first, then req1 ----
        rst_n = 1'b1;
        #1;
        chk("cont_rdy0_first", req0_ready, 1);
        chk("cont_rdy1_first", req1_ready, 0);
        step();                                   // E0: req0 accepted
        drv(0, 0, 0, 0, 1, MUL, 4, 9);
        #1;
        chk("cont_rdy1_second", req1_ready, 1);
        step();                                   // E1: req1 accepted
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("cont_alu_op", alu_op, MUL);
        chk("cont_alu_in1", alu_in1, 4);
        chk("cont_rsp0_early", rsp0_valid, 0);
        step();                                   // E2
        chk("cont_rsp0_valid", rsp0_valid, 1);
        chk("cont_rsp0_data", rsp0_data, 11);
        chk("cont_rsp1_idle", rsp1_valid, 0);
        step();                                   // E3
        chk("cont_rsp0_drop", rsp0_valid, 0);
        chk("cont_rsp1_valid", rsp1_valid, 1);
        chk("cont_rsp1_data", rsp1_data, 36);

        // ---- single request on req0 ----
        drv(1, ADD, 5, 7, 0, 0, 0, 0);
        #1;
        chk("single_rdy0", req0_ready, 1);
        step();                                   // E0
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("single_alu_op", alu_op, ADD);
        chk("single_alu_in1", alu_in1, 5);
        chk("single_alu_in2", alu_in2, 7);
        chk("single_rsp1_e0", rsp1_valid, 0);
        step();                                   // E1
        chk("single_rsp0_e1", rsp0_valid, 0);
        chk("single_rsp1_e1", rsp1_valid, 0);
        step();                                   // E2
        chk("single_rsp0_valid", rsp0_valid, 1);
        chk("single_rsp0_data", rsp0_data, 12);
        chk("single_rsp1_e2", rsp1_valid, 0);
        step();                                   // E3
        chk("single_rsp0_pulse", rsp0_valid, 0);
        chk("single_rsp0_hold", rsp0_data, 12);

        // ---- reset mid-flight ----
        drv(1, ADD, 5, 7, 0, 0, 0, 0);
        step();                                   // E0: accepted
        rst_n = 1'b0;
        drv(1, ADD, 1, 1, 1, ADD, 2, 2);
        #1;
        chk("midrst_rdy0_low", req0_ready, 0);
        chk("midrst_rdy1_low", req1_ready, 0);
        step();                                   // E1: reset edge
        chk("midrst_rsp0_e1", rsp0_valid, 0);
        step();                                   // E2: old op would have answered here
        chk("midrst_rsp0_e2", rsp0_valid, 0);
        chk("midrst_rsp0_data", rsp0_data, 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rdy0_after", req0_ready, 1);
        chk("midrst_rdy1_after", req1_ready, 0);
        step();                                   // E3: req0 ADD 1,1
        drv(0, 0, 0, 0, 1, ADD, 2, 2);
        chk("midrst_rsp0_e3", rsp0_valid, 0);
        step();                                   // E4: req1 ADD 2,2
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst_rsp0_e4", rsp0_valid, 0);
        step();                                   // E5
        chk("midrst_rsp0_new", rsp0_valid, 1);
        chk("midrst_rsp0_new_data", rsp0_data, 2);
        step();                                   // E6
        chk("midrst_rsp1_new", rsp1_valid, 1);
        chk("midrst_rsp1_new_data", rsp1_data, 4);

        // ---- table: streaming, contention, strict alternation ----
        do_reset();
        for (int r = 0; r < 23; r++) begin
            drv(tbl[r].v0, tbl[r].op0, tbl[r].a0, tbl[r].b0,
                tbl[r].v1, tbl[r].op1, tbl[r].a1, tbl[r].b1);
            #1;
            chk($sformatf("tbl%0d_rdy0", r), req0_ready, tbl[r].rdy0);
            chk($sformatf("tbl%0d_rdy1", r), req1_ready, tbl[r].rdy1);
            step();
            chk($sformatf("tbl%0d_rsp0_valid", r), rsp0_valid, tbl[r].rv0);
            chk($sformatf("tbl%0d_rsp0_data", r), rsp0_data, tbl[r].rd0);
            chk($sformatf("tbl%0d_rsp1_valid", r), rsp1_valid, tbl[r].rv1);
            chk($sformatf("tbl%0d_rsp1_data", r), rsp1_data, tbl[r].rd1);
        end

        // ---- stats: 10 req0 ops then 3 req1 ops ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drv(1, ADD, 16'(i), 1, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 1, SUB, 16'(i), 1);
            step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step();
`ifdef ALU_ARB_STATS_EN
        exp_c0 = 16'd10;
        exp_c1 = 16'd3;
`else
        exp_c0 = 16'd0;
        exp_c1 = 16'd0;
`endif
        chk("stats_cnt0", grant_cnt0, exp_c0);
        chk("stats_cnt1", grant_cnt1, exp_c1);

        // ---- ALU_LATENCY = 3: req1 OR 9,12 ----
        b_req1_valid = 1'b1; b_req1_op = OR_; b_req1_in1 = 16'd9; b_req1_in2 = 16'd12;
        #1;
        chk("lat3_rdy1", b_req1_ready, 1);
        step();                                   // E0
        b_req1_valid = 1'b0;
        chk("lat3_rsp1_e0", b_rsp1_valid, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("lat3_rsp1_e%0d", k), b_rsp1_valid, 0);
        end
        step();                                   // E4
        chk("lat3_rsp1_valid", b_rsp1_valid, 1);
        chk("lat3_rsp1_data", b_rsp1_data, 13);
        chk("lat3_rsp0_idle", b_rsp0_valid, 0);
        step();                                   // E5
        chk("lat3_rsp1_pulse", b_rsp1_valid, 0);
        chk("lat3_rsp1_hold", b_rsp1_data, 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
